// File: rtl/icache_port_pkg.sv
// icache_port_pkg: shared types and constants for the direct-mapped instruction cache.
package icache_port_pkg;
  localparam int ICACHE_SETS = 8;
  localparam int ICACHE_IW = $clog2(ICACHE_SETS);
  typedef logic [15:0] lc3b_word;
  typedef logic [127:0] lc3b_line;
  typedef logic [11-ICACHE_IW:0] lc3b_c_tag;
  typedef logic [ICACHE_IW-1:0] lc3b_c_index;
  typedef logic [2:0] lc3b_c_word;
  typedef enum logic {IDLE, FILL} icache_state_e;
endpackage

// File: rtl/icache_array.sv
// icache_array: NUM_SETS entries of {valid, tag, line}, async read by index, sync write on load.
module icache_array
  import icache_port_pkg::*;
#(
  parameter int NUM_SETS = ICACHE_SETS,
  parameter int IW = $clog2(NUM_SETS),
  parameter int TW = 12 - IW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [IW-1:0] i_rindex,
  input  logic          i_load,
  input  logic [IW-1:0] i_windex,
  input  logic [TW-1:0] i_tag,
  input  lc3b_line      i_line,
  output logic          o_valid,
  output logic [TW-1:0] o_tag,
  output lc3b_line      o_line
);
  logic [NUM_SETS-1:0] r_valid;
  logic [TW-1:0] r_tag [NUM_SETS];
  lc3b_line r_line [NUM_SETS];
  // Only valid bits are reset; tag/data are qualified by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_valid <= '0;
    else if (i_load) r_valid[i_windex] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (i_load) begin
      r_tag[i_windex] <= i_tag;
      r_line[i_windex] <= i_line;
    end
  end
  assign o_valid = r_valid[i_rindex];
  assign o_tag = r_tag[i_rindex];
  assign o_line = r_line[i_rindex];
endmodule

// File: rtl/icache_port.sv
// icache_port: read-only direct-mapped I-cache; zero-latency hits, misses filled over a 128-bit pmem line port.
module icache_port
  import icache_port_pkg::*;
#(
  parameter int NUM_SETS = ICACHE_SETS,
  parameter int LINE_WORDS = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     read_a,
  input  lc3b_word address_a,
  output logic     resp_a,
  output lc3b_word rdata_a,
  output logic     pmem_read,
  output lc3b_word pmem_address,
  input  lc3b_line pmem_rdata,
  input  logic     pmem_resp
);
  localparam int IW = $clog2(NUM_SETS);
  localparam int WW = $clog2(LINE_WORDS);
  localparam int TW = 12 - IW;
  icache_state_e r_state, w_next;
  logic [11:0] r_fill_line;
  logic [IW-1:0] w_index;
  logic [TW-1:0] w_tag, w_arr_tag;
  logic [WW-1:0] w_word;
  logic w_valid, w_hit, w_load, w_unused;
  lc3b_line w_arr_line;
  assign w_tag = address_a[15:4+IW];
  assign w_index = address_a[3+IW:4];
  assign w_word = address_a[WW:1];
  assign w_unused = address_a[0];
  icache_array #(.NUM_SETS(NUM_SETS), .IW(IW), .TW(TW)) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_rindex (w_index),
    .i_load   (w_load),
    .i_windex (r_fill_line[IW-1:0]),
    .i_tag    (r_fill_line[11:IW]),
    .i_line   (pmem_rdata),
    .o_valid  (w_valid),
    .o_tag    (w_arr_tag),
    .o_line   (w_arr_line)
  );
  assign w_hit = read_a & w_valid & (w_arr_tag == w_tag);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_fill_line <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && read_a && !w_hit) r_fill_line <= address_a[15:4];
    end
  end
  // pmem_resp outside FILL never reaches the array.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    if (r_state == IDLE) w_next = (read_a && !w_hit) ? FILL : IDLE;
    else if (pmem_resp) begin
      w_next = IDLE;
      w_load = 1'b1;
    end
  end
  assign resp_a = (r_state == IDLE) & w_hit;
  assign rdata_a = resp_a ? w_arr_line[{w_word, 4'b0} +: 16] : '0;
  assign pmem_read = (r_state == FILL);
  assign pmem_address = {r_fill_line, 4'b0};
endmodule

// File: tb/tb_icache_port.sv
// tb_icache_port: directed tests for icache_port with a simple pmem responder.
module tb_icache_port;
  logic clk, rst_n, read_a, resp_a, pmem_read, pmem_resp;
  logic [15:0] address_a, rdata_a, pmem_address;
  logic [127:0] pmem_rdata;
  int pass_cnt = 0;
  int total = 0;

  icache_port dut (
    .clk(clk), .rst_n(rst_n), .read_a(read_a), .address_a(address_a),
    .resp_a(resp_a), .rdata_a(rdata_a), .pmem_read(pmem_read),
    .pmem_address(pmem_address), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] line_of(input logic [15:0] a);
    logic [127:0] l;
    for (int n = 0; n < 8; n++) l[16*n +: 16] = {a[15:4], 4'(n)};
    return l;
  endfunction

  function automatic logic [15:0] exp_word(input logic [15:0] a);
    return {a[15:4], 1'b0, a[3:1]};
  endfunction

  // Waits for a fill request, holds it lat cycles, then answers with line_of(address).
  task automatic do_fill(input int lat, output logic [15:0] addr, output logic ok);
    int n;
    n = 0;
    ok = 1'b0;
    addr = 'x;
    while (!pmem_read && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    if (!pmem_read) return;
    addr = pmem_address;
    ok = 1'b1;
    repeat (lat) begin
      @(negedge clk); #1;
      if (!pmem_read || pmem_address !== addr || resp_a) ok = 1'b0;
    end
    pmem_rdata = line_of(addr);
    pmem_resp = 1'b1;
    #1;
    if (resp_a) ok = 1'b0;
    @(negedge clk);
    pmem_resp = 1'b0;
    pmem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; read_a = 1'b1; address_a = 16'h0000; pmem_resp = 1'b0; pmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    total++; if (pmem_read !== 1'b0) $display("FAIL reset_pmem_read got %b want 0", pmem_read); else pass_cnt++;
    total++; if (resp_a !== 1'b0) $display("FAIL reset_resp_a got %b want 0", resp_a); else pass_cnt++;
    total++; if (rdata_a !== 16'h0) $display("FAIL reset_rdata_a got %h want 0000", rdata_a); else pass_cnt++;
    @(negedge clk);
    read_a = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_cold_fetch;
    logic [15:0] a;
    logic ok;
    @(negedge clk);
    read_a = 1'b1; address_a = 16'h0000;
    #1;
    total++; if (resp_a !== 1'b0) $display("FAIL cold_miss_resp got %b want 0", resp_a); else pass_cnt++;
    total++; if (pmem_read !== 1'b0) $display("FAIL cold_miss_cycle_pmem got %b want 0", pmem_read); else pass_cnt++;
    do_fill(3, a, ok);
    total++; if (ok !== 1'b1) $display("FAIL cold_fill_handshake got %b want 1", ok); else pass_cnt++;
    total++; if (a !== 16'h0000) $display("FAIL cold_pmem_address got %h want 0000", a); else pass_cnt++;
    total++; if (resp_a !== 1'b1) $display("FAIL cold_resp got %b want 1", resp_a); else pass_cnt++;
    total++; if (rdata_a !== 16'h0000) $display("FAIL cold_rdata got %h want 0000", rdata_a); else pass_cnt++;
  endtask

  task automatic test_hits;
    logic [15:0] addrs [4] = '{16'h0002, 16'h000E, 16'h0003, 16'h0008};
    foreach (addrs[i]) begin
      @(negedge clk);
      address_a = addrs[i];
      #1;
      total++; if (resp_a !== 1'b1) $display("FAIL hit_resp[%h] got %b want 1", addrs[i], resp_a); else pass_cnt++;
      total++; if (rdata_a !== exp_word(addrs[i])) $display("FAIL hit_rdata[%h] got %h want %h", addrs[i], rdata_a, exp_word(addrs[i])); else pass_cnt++;
      total++; if (pmem_read !== 1'b0) $display("FAIL hit_pmem_read[%h] got %b want 0", addrs[i], pmem_read); else pass_cnt++;
    end
    @(negedge clk);
    read_a = 1'b0;
    #1;
    total++; if (resp_a !== 1'b0) $display("FAIL idle_resp got %b want 0", resp_a); else pass_cnt++;
    total++; if (rdata_a !== 16'h0) $display("FAIL idle_rdata got %h want 0000", rdata_a); else pass_cnt++;
  endtask

  task automatic test_conflict;
    logic [15:0] a;
    logic ok;
    @(negedge clk);
    read_a = 1'b1; address_a = 16'h0080;
    #1;
    total++; if (resp_a !== 1'b0) $display("FAIL conflict_miss got %b want 0", resp_a); else pass_cnt++;
    do_fill(2, a, ok);
    total++; if (ok !== 1'b1 || a !== 16'h0080) $display("FAIL conflict_fill_addr got %h ok=%b want 0080", a, ok); else pass_cnt++;
    total++; if (rdata_a !== 16'h0080 || resp_a !== 1'b1) $display("FAIL conflict_rdata got %h resp=%b want 0080", rdata_a, resp_a); else pass_cnt++;
    @(negedge clk);
    address_a = 16'h0000;
    #1;
    total++; if (resp_a !== 1'b0) $display("FAIL evicted_miss got %b want 0", resp_a); else pass_cnt++;
    do_fill(1, a, ok);
    total++; if (ok !== 1'b1 || a !== 16'h0000) $display("FAIL evicted_fill_addr got %h ok=%b want 0000", a, ok); else pass_cnt++;
    total++; if (rdata_a !== 16'h0000 || resp_a !== 1'b1) $display("FAIL evicted_rdata got %h resp=%b want 0000", rdata_a, resp_a); else pass_cnt++;
  endtask

  task automatic test_redirect;
    logic [15:0] a;
    logic ok;
    @(negedge clk);
    address_a = 16'h0030;
    @(negedge clk); #1;
    total++; if (pmem_read !== 1'b1) $display("FAIL redirect_fill_start got %b want 1", pmem_read); else pass_cnt++;
    address_a = 16'h0100;
    do_fill(3, a, ok);
    total++; if (ok !== 1'b1 || a !== 16'h0030) $display("FAIL redirect_fill_addr got %h ok=%b want 0030", a, ok); else pass_cnt++;
    total++; if (resp_a !== 1'b0) $display("FAIL redirect_relookup_resp got %b want 0", resp_a); else pass_cnt++;
    do_fill(2, a, ok);
    total++; if (ok !== 1'b1 || a !== 16'h0100) $display("FAIL redirect_second_fill got %h ok=%b want 0100", a, ok); else pass_cnt++;
    total++; if (resp_a !== 1'b1 || rdata_a !== 16'h0100) $display("FAIL redirect_rdata got %h resp=%b want 0100", rdata_a, resp_a); else pass_cnt++;
    @(negedge clk);
    address_a = 16'h0036;
    #1;
    total++; if (resp_a !== 1'b1 || rdata_a !== 16'h0033) $display("FAIL redirect_installed got %h resp=%b want 0033", rdata_a, resp_a); else pass_cnt++;
  endtask

  task automatic test_read_drop;
    logic [15:0] a;
    logic ok;
    @(negedge clk);
    address_a = 16'h0050;
    @(negedge clk);
    read_a = 1'b0;
    do_fill(2, a, ok);
    total++; if (ok !== 1'b1 || a !== 16'h0050) $display("FAIL drop_fill_addr got %h ok=%b want 0050", a, ok); else pass_cnt++;
    total++; if (resp_a !== 1'b0) $display("FAIL drop_no_resp got %b want 0", resp_a); else pass_cnt++;
    @(negedge clk);
    read_a = 1'b1; address_a = 16'h0052;
    #1;
    total++; if (resp_a !== 1'b1 || rdata_a !== 16'h0051) $display("FAIL drop_installed got %h resp=%b want 0051", rdata_a, resp_a); else pass_cnt++;
  endtask

  task automatic test_reset_mid_fill;
    logic [15:0] a;
    logic ok;
    @(negedge clk);
    address_a = 16'h0040;
    @(negedge clk); #1;
    total++; if (pmem_read !== 1'b1) $display("FAIL rstfill_start got %b want 1", pmem_read); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total++; if (pmem_read !== 1'b0) $display("FAIL rstfill_async_drop got %b want 0", pmem_read); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (resp_a !== 1'b0) $display("FAIL rstfill_remiss got %b want 0", resp_a); else pass_cnt++;
    do_fill(2, a, ok);
    total++; if (ok !== 1'b1 || a !== 16'h0040) $display("FAIL rstfill_refill got %h ok=%b want 0040", a, ok); else pass_cnt++;
    total++; if (resp_a !== 1'b1 || rdata_a !== 16'h0040) $display("FAIL rstfill_rdata got %h resp=%b want 0040", rdata_a, resp_a); else pass_cnt++;
  endtask

  task automatic test_spurious_resp;
    @(negedge clk);
    read_a = 1'b0;
    pmem_rdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    total++; if (pmem_read !== 1'b0) $display("FAIL spurious_pmem_read got %b want 0", pmem_read); else pass_cnt++;
    @(negedge clk);
    read_a = 1'b1; address_a = 16'h004E;
    #1;
    total++; if (resp_a !== 1'b1 || rdata_a !== 16'h0047) $display("FAIL spurious_hit_idx4 got %h resp=%b want 0047", rdata_a, resp_a); else pass_cnt++;
    @(negedge clk);
    pmem_resp = 1'b1;
    address_a = 16'h0042;
    #1;
    total++; if (resp_a !== 1'b1 || rdata_a !== 16'h0041) $display("FAIL spurious_hit_during_resp got %h resp=%b want 0041", rdata_a, resp_a); else pass_cnt++;
    @(negedge clk);
    pmem_resp = 1'b0;
    address_a = 16'h0044;
    #1;
    total++; if (resp_a !== 1'b1 || rdata_a !== 16'h0042) $display("FAIL spurious_after got %h resp=%b want 0042", rdata_a, resp_a); else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_cold_fetch;
    test_hits;
    test_conflict;
    test_redirect;
    test_read_drop;
    test_reset_mid_fill;
    test_spurious_resp;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
